// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl_pkg
// Description : Shared constants for the program-counter sequencer.
//               Contents:
//               - FSM state encoding (2 bits).
//               - Opcode and extension fields.
//               - Condition codes.
//               - PSR flag bit positions.
//               - A helper that classifies memory instructions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_MEM    = 2'b11
  } state_t;

  // Instruction fields: ir[15:12] = op, ir[11:8] = cond/rdest,
  // ir[7:4] = ext, ir[3:0] = rsrc.
  localparam logic [3:0] OP_REG    = 4'b0000;  // register-register ALU class
  localparam logic [3:0] OP_SPEC   = 4'b0100;  // load/store/jump class
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_MOVI   = 4'b1101;
  localparam logic [3:0] OP_LUI    = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_MOV   = 4'b1101;  // MOV within OP_REG

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // PSR layout {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_mem_op(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_SPEC) && ((ext == EXT_LOAD) || (ext == EXT_STOR));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Evaluates a 4-bit branch/jump condition against PSR flags.
//               Purely combinational.
// Ports       : cond      in  4  condition field from ir[11:8]
//               flags     in  5  PSR {C,L,F,Z,N}
//               cond_true out 1  condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_EQ:   cond_true =  flags[FLAG_Z];
      CC_NE:   cond_true = ~flags[FLAG_Z];
      CC_CS:   cond_true =  flags[FLAG_C];
      CC_CC:   cond_true = ~flags[FLAG_C];
      CC_HI:   cond_true =  flags[FLAG_L];
      CC_LS:   cond_true = ~flags[FLAG_L];
      CC_GT:   cond_true =  flags[FLAG_N];
      CC_LE:   cond_true = ~flags[FLAG_N];
      CC_FS:   cond_true =  flags[FLAG_F];
      CC_FC:   cond_true = ~flags[FLAG_F];
      CC_LO:   cond_true = ~flags[FLAG_L] & ~flags[FLAG_Z];
      CC_HS:   cond_true =  flags[FLAG_L] |  flags[FLAG_Z];
      CC_LT:   cond_true = ~flags[FLAG_N] & ~flags[FLAG_Z];
      CC_GE:   cond_true =  flags[FLAG_N] |  flags[FLAG_Z];
      CC_UC:   cond_true = 1'b1;
      CC_NV:   cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Multi-cycle sequencer for the program counter. Fetches an
//               instruction over a req/ready handshake, decodes its class,
//               then either executes (ALU / branch / jump) or performs a
//               data-memory access, issuing exactly one pcEn per retired
//               instruction.
// Ports       : clk        in   1  clock, rising edge
//               rst        in   1  asynchronous reset, active low
//               run        in   1  permit a new fetch
//               imem_req   out  1  instruction fetch request
//               imem_ready in   1  instruction word valid
//               imem_data  in   DATAWIDTH instruction word
//               dmem_req   out  1  data access request
//               dmem_we    out  1  1 = store, 0 = load
//               dmem_ready in   1  data access complete
//               flags      in   5  PSR {C,L,F,Z,N}
//               ir         out  DATAWIDTH instruction register
//               irEn       out  1  IR load strobe
//               regWrEn    out  1  regfile write strobe
//               flagEn     out  1  PSR update strobe
//               pcEn       out  1  pc update strobe
//               branch     out  1  pc adds sign-extended displacement
//               jump       out  1  pc loads register target
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int IMMWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [DATAWIDTH-1:0] imem_data,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic [4:0]           flags,
  output logic [DATAWIDTH-1:0] ir,
  output logic                 irEn,
  output logic                 regWrEn,
  output logic                 flagEn,
  output logic                 pcEn,
  output logic                 branch,
  output logic                 jump
);

  // The decode below uses fixed 16-bit field positions, and the displacement
  // must not reach into the condition/opcode fields.
  if (DATAWIDTH != 16 || IMMWIDTH > DATAWIDTH - 8) begin : g_param_check
    $error("pc_ctrl: unsupported DATAWIDTH/IMMWIDTH combination");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [DATAWIDTH-1:0]   r_ir;

  logic [3:0] w_op;
  logic [3:0] w_ext;
  logic       w_cond_true;
  logic       w_is_mem;
  logic       w_is_stor;
  logic       w_is_bcond;
  logic       w_is_jcond;
  logic       w_is_jal;
  logic       w_is_alu;
  logic       w_no_flags;

  logic w_imem_req;
  logic w_ir_en;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_reg_wr;
  logic w_flag_en;
  logic w_pc_en;
  logic w_branch;
  logic w_jump;

  assign w_op       = r_ir[15:12];
  assign w_ext      = r_ir[7:4];
  assign w_is_mem   = is_mem_op(w_op, w_ext);
  assign w_is_stor  = (w_op == OP_SPEC) && (w_ext == EXT_STOR);
  assign w_is_bcond = (w_op == OP_BCOND);
  assign w_is_jcond = (w_op == OP_SPEC) && (w_ext == EXT_JCOND);
  assign w_is_jal   = (w_op == OP_SPEC) && (w_ext == EXT_JAL);
  // Every opcode outside the special and Bcond groups is a register or
  // immediate ALU operation. Unlisted OP_SPEC extensions fall through as NOP.
  assign w_is_alu   = (w_op != OP_SPEC) && (w_op != OP_BCOND);
  // Moves only copy data; they leave the PSR untouched.
  assign w_no_flags = ((w_op == OP_REG) && (w_ext == EXT_MOV)) ||
                      (w_op == OP_MOVI) || (w_op == OP_LUI);

  cond_eval u_cond_eval (
    .cond      (r_ir[11:8]),
    .flags     (flags),
    .cond_true (w_cond_true)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_en) begin
        r_ir <= imem_data;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_en    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_reg_wr   = 1'b0;
    w_flag_en  = 1'b0;
    w_pc_en    = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = run;
        if (run && imem_ready) begin
          w_ir_en = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_is_mem ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
        if (w_is_bcond) begin
          w_branch = w_cond_true;
        end else if (w_is_jcond) begin
          w_jump = w_cond_true;
        end else if (w_is_jal) begin
          w_reg_wr = 1'b1;
          w_jump   = 1'b1;
        end else if (w_is_alu) begin
          w_reg_wr  = 1'b1;
          w_flag_en = ~w_no_flags;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_stor;
        if (dmem_ready) begin
          w_reg_wr = ~w_is_stor;
          w_pc_en  = 1'b1;
          w_next   = S_FETCH;
        end
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset also masks the outputs combinationally so that a request in flight
  // (imem_req in FETCH, dmem_req in MEM) drops the moment rst goes low.
  assign imem_req = rst & w_imem_req;
  assign irEn     = rst & w_ir_en;
  assign dmem_req = rst & w_dmem_req;
  assign dmem_we  = rst & w_dmem_we;
  assign regWrEn  = rst & w_reg_wr;
  assign flagEn   = rst & w_flag_en;
  assign pcEn     = rst & w_pc_en;
  assign branch   = rst & w_branch;
  assign jump     = rst & w_jump;
  assign ir       = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Self-checking bench for pc_ctrl. Directed instructions and
//               randomized instruction streams are compared cycle by cycle
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [15:0] imem_data = '0;
  logic [4:0]  flags = '0;

  logic        imem_req, dmem_req, dmem_we;
  logic [15:0] ir;
  logic        irEn, regWrEn, flagEn, pcEn, branch, jump;

  logic [8:0]  obs;

  int checks = 0;
  int errors = 0;

  pc_ctrl #(.DATAWIDTH(16), .IMMWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .flags      (flags),
    .ir         (ir),
    .irEn       (irEn),
    .regWrEn    (regWrEn),
    .flagEn     (flagEn),
    .pcEn       (pcEn),
    .branch     (branch),
    .jump       (jump)
  );

  always #5 clk = ~clk;

  // Bit order: imem_req irEn dmem_req dmem_we regWrEn flagEn pcEn branch jump
  assign obs = {imem_req, irEn, dmem_req, dmem_we, regWrEn, flagEn, pcEn, branch, jump};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] vec(input bit ireq, input bit ien, input bit dreq,
                                     input bit dwe, input bit rw, input bit fe,
                                     input bit pe, input bit br, input bit jp);
    return {ireq, ien, dreq, dwe, rw, fe, pe, br, jp};
  endfunction

  // Condition table written straight from the flag meanings {C,L,F,Z,N}.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [4:0] f);
    bit c, l, fl, z, n;
    c = f[4]; l = f[3]; fl = f[2]; z = f[1]; n = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return fl;
      4'd9:  return !fl;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit mem_instr(input logic [15:0] ins);
    return (ins[15:12] == 4'h4) && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4);
  endfunction

  // Expected strobes in the single execute cycle of a non-memory instruction.
  function automatic logic [8:0] exp_exec(input logic [15:0] ins, input logic [4:0] f);
    logic [3:0] op, ext, cc;
    bit         keep_flags;
    op = ins[15:12]; ext = ins[7:4]; cc = ins[11:8];
    if (op == 4'hC) return vec(0, 0, 0, 0, 0, 0, 1, cond_ok(cc, f), 0);
    if (op == 4'h4) begin
      if (ext == 4'hC) return vec(0, 0, 0, 0, 0, 0, 1, 0, cond_ok(cc, f));
      if (ext == 4'h8) return vec(0, 0, 0, 0, 1, 0, 1, 0, 1);
      return vec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    keep_flags = (op == 4'h0 && ext == 4'hD) || op == 4'hD || op == 4'hF;
    return vec(0, 0, 0, 0, 1, !keep_flags, 1, 0, 0);
  endfunction

  // Runs one instruction from S_FETCH back to S_FETCH. Entered and left
  // #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic run_instr(input logic [15:0] ins, input logic [4:0] f,
                           input int fw, input int mw, input string tag);
    bit st;
    st = (ins[7:4] == 4'h4);
    flags = f;
    run   = 1'b1;
    for (int i = 0; i < fw; i++) begin
      imem_ready = 1'b0;
      imem_data  = 16'($urandom);
      dmem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s_fwait", tag), 32'(obs), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0, 0)));
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    imem_data  = ins;
    dmem_ready = 1'($urandom);
    @(negedge clk);
    check($sformatf("%s_fetch", tag), 32'(obs), 32'(vec(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    check($sformatf("%s_ir", tag), 32'(ir), 32'(ins));
    // run and imem_ready are don't-cares outside S_FETCH
    run        = 1'($urandom);
    imem_ready = 1'($urandom);
    imem_data  = 16'($urandom);
    dmem_ready = 1'($urandom);
    @(negedge clk);
    check($sformatf("%s_decode", tag), 32'(obs), 32'(vec(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    if (mem_instr(ins)) begin
      for (int i = 0; i < mw; i++) begin
        run        = 1'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s_mwait", tag), 32'(obs), 32'(vec(0, 0, 1, st, 0, 0, 0, 0, 0)));
        @(posedge clk); #1;
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      check($sformatf("%s_mdone", tag), 32'(obs), 32'(vec(0, 0, 1, st, !st, 0, 1, 0, 0)));
      @(posedge clk); #1;
    end else begin
      run        = 1'($urandom);
      imem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s_exec", tag), 32'(obs), 32'(exp_exec(ins, f)));
      @(posedge clk); #1;
    end
    run        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  function automatic logic [15:0] gen_instr();
    logic [3:0] alu_ops [10];
    logic [15:0] w;
    alu_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'h9, 4'hB, 4'hD, 4'hF};
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0: w[15:12] = alu_ops[$urandom_range(0, 9)];
      1: w[15:12] = 4'hC;
      2: begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
      3: begin w[15:12] = 4'h4; w[7:4] = 4'h8; end
      4: begin w[15:12] = 4'h4; w[7:4] = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'h0; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Reset held for three cycles with run and imem_ready high
    rst = 1'b0; run = 1'b1; imem_ready = 1'b1; imem_data = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_out", 32'(obs), 32'd0);
      check("rst_ir", 32'(ir), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    check("rst_release", 32'(obs), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;

    run_instr(16'h0521, 5'b00000, 0, 0, "add");
    run_instr(16'hD312, 5'b11111, 1, 0, "movi");
    run_instr(16'hC0FC, 5'b00010, 0, 0, "beq_t");
    run_instr(16'hC0FC, 5'b00000, 0, 0, "beq_n");
    run_instr(16'hCDFC, 5'b00000, 0, 0, "bge_n");
    run_instr(16'h4EC3, 5'b00000, 0, 0, "juc");
    run_instr(16'h4FC3, 5'b11111, 0, 0, "jnv");
    run_instr(16'h4E83, 5'b00000, 0, 0, "jal");
    run_instr(16'h4203, 5'b00000, 0, 3, "load");
    run_instr(16'h4243, 5'b00000, 2, 1, "stor");
    run_instr(16'h4273, 5'b00000, 0, 0, "undef");

    // Reset asserted while a load waits in S_MEM
    imem_ready = 1'b1; imem_data = 16'h4203; run = 1'b1;
    @(negedge clk);
    check("abort_fetch", 32'(obs), 32'(vec(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("abort_mwait", 32'(obs), 32'(vec(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    rst = 1'b0; dmem_ready = 1'b1;
    #1;
    check("abort_drop", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    check("abort_restart", 32'(obs), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("abort_ir", 32'(ir), 32'd0);
    @(posedge clk); #1;

    // Halted: run low keeps the sequencer idle even with imem_ready high
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom);
      imem_data  = 16'($urandom);
      @(negedge clk);
      check("halt", 32'(obs), 32'd0);
      @(posedge clk); #1;
    end
    check("halt_ir", 32'(ir), 32'd0);
    imem_ready = 1'b0;

    for (int n = 0; n < 80; n++) begin
      run_instr(gen_instr(), 5'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
